// File: rtl/seg_scan_arbiter.sv
// Four-digit seven-segment scanner shared by a background source (A) and a
// req/gnt source (B); ownership and digit snapshots change only at frame ends.
module seg_scan_arbiter #(
   parameter int DWELL_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int HOLD_FRAMES  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] a_dig_0,
   input  logic [7:0] a_dig_1,
   input  logic [7:0] a_dig_2,
   input  logic [7:0] a_dig_3,
   input  logic       b_req,
   output logic       b_gnt,
   input  logic [7:0] b_dig_0,
   input  logic [7:0] b_dig_1,
   input  logic [7:0] b_dig_2,
   input  logic [7:0] b_dig_3,
   output logic [3:0] an,
   output logic [7:0] sseg
);

   localparam int TICK_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DWELL_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

   typedef enum logic {OWN_A, OWN_B} owner_t;

   logic [TICK_W-1:0] r_tick;
   logic [1:0]        r_sel;
   owner_t            r_owner;
   owner_t            w_owner_nxt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic [7:0]        r_snap [4];
   logic              r_valid;
   logic [3:0]        r_an;
   logic [7:0]        r_sseg;
   logic              r_b_gnt;

   logic              w_tick_wrap;
   logic              w_frame_end;
   logic              w_blank;
   logic [7:0]        w_a_dig [4];
   logic [7:0]        w_b_dig [4];

   assign w_a_dig[0] = a_dig_0;
   assign w_a_dig[1] = a_dig_1;
   assign w_a_dig[2] = a_dig_2;
   assign w_a_dig[3] = a_dig_3;
   assign w_b_dig[0] = b_dig_0;
   assign w_b_dig[1] = b_dig_1;
   assign w_b_dig[2] = b_dig_2;
   assign w_b_dig[3] = b_dig_3;

   assign w_tick_wrap = (r_tick == TICK_LAST);
   assign w_frame_end = w_tick_wrap && (r_sel == 2'd3);

   // With no blanking window the comparison would be constant, so elide it.
   generate
      if (BLANK_CYCLES == 0) begin : g_no_blank
         assign w_blank = 1'b0;
      end else begin : g_blank
         localparam logic [TICK_W-1:0] BLANK_T = TICK_W'(BLANK_CYCLES);
         assign w_blank = (r_tick < BLANK_T);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick <= '0;
         r_sel  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
         if (w_tick_wrap) r_sel <= r_sel + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner    <= OWN_A;
         r_hold_cnt <= '0;
         r_b_gnt    <= 1'b0;
      end else begin
         r_owner    <= w_owner_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_b_gnt    <= (w_owner_nxt == OWN_B);
      end
   end

   always_comb begin
      // NOTE: defaults first keep every path assigned, so no latch is inferred.
      w_owner_nxt = r_owner;
      w_hold_nxt  = r_hold_cnt;
      if (w_frame_end) begin
         case (r_owner)
            OWN_A: begin
               if (b_req) begin
                  w_owner_nxt = OWN_B;
                  w_hold_nxt  = '0;
               end
            end
            OWN_B: begin
               if (!b_req && (r_hold_cnt == HOLD_LAST)) begin
                  w_owner_nxt = OWN_A;
               end else if (r_hold_cnt != HOLD_LAST) begin
                  w_hold_nxt = r_hold_cnt + 1'b1;
               end
            end
            default: w_owner_nxt = OWN_A;
         endcase
      end
   end

   // r_valid keeps the very first frame after reset fully dark (anodes off too).
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the four snapshot registers are reset so the first frame is dark, not X.
         for (int i = 0; i < 4; i++) r_snap[i] <= 8'hFF;
         r_valid <= 1'b0;
      end else if (w_frame_end) begin
         for (int i = 0; i < 4; i++)
            r_snap[i] <= (w_owner_nxt == OWN_B) ? w_b_dig[i] : w_a_dig[i];
         r_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_an   <= 4'b1111;
         r_sseg <= 8'hFF;
      end else if (w_blank || !r_valid) begin
         r_an   <= 4'b1111;
         r_sseg <= 8'hFF;
      end else begin
         r_an   <= ~(4'b0001 << r_sel);
         r_sseg <= r_snap[r_sel];
      end
   end

   assign an    = r_an;
   assign sseg  = r_sseg;
   assign b_gnt = r_b_gnt;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Randomised and directed bench for seg_scan_arbiter against a frame-level
// model derived from the cycle count since reset (blanked and unblanked copies).
module tb_seg_scan_arbiter;

   localparam int D  = 8;
   localparam int BL = 2;
   localparam int H  = 2;
   localparam int FRAME = 4 * D;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       b_req = 1'b0;
   logic [7:0] a_dig [4];
   logic [7:0] b_dig [4];
   logic [3:0] an_b, an_z;
   logic [7:0] sseg_b, sseg_z;
   logic       gnt_b, gnt_z;

   int checks = 0;
   int errors = 0;

   // model state
   int         n;
   bit         own;
   int         hold;
   bit         valid;
   logic [7:0] snap [4];
   logic [3:0] e_an_b, e_an_z;
   logic [7:0] e_sseg_b, e_sseg_z;
   logic       e_gnt;

   always #5 clk = ~clk;

   seg_scan_arbiter #(.DWELL_CYCLES(D), .BLANK_CYCLES(BL), .HOLD_FRAMES(H)) dut_b (
      .clk(clk), .reset(reset),
      .a_dig_0(a_dig[0]), .a_dig_1(a_dig[1]), .a_dig_2(a_dig[2]), .a_dig_3(a_dig[3]),
      .b_req(b_req), .b_gnt(gnt_b),
      .b_dig_0(b_dig[0]), .b_dig_1(b_dig[1]), .b_dig_2(b_dig[2]), .b_dig_3(b_dig[3]),
      .an(an_b), .sseg(sseg_b)
   );

   seg_scan_arbiter #(.DWELL_CYCLES(D), .BLANK_CYCLES(0), .HOLD_FRAMES(H)) dut_z (
      .clk(clk), .reset(reset),
      .a_dig_0(a_dig[0]), .a_dig_1(a_dig[1]), .a_dig_2(a_dig[2]), .a_dig_3(a_dig[3]),
      .b_req(b_req), .b_gnt(gnt_z),
      .b_dig_0(b_dig[0]), .b_dig_1(b_dig[1]), .b_dig_2(b_dig[2]), .b_dig_3(b_dig[3]),
      .an(an_z), .sseg(sseg_z)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Expected outputs after the coming edge, from the inputs currently applied.
   task automatic model_step();
      int  tick;
      int  sel;
      bit  dark;
      if (reset) begin
         n = 0; own = 0; hold = 0; valid = 0;
         for (int i = 0; i < 4; i++) snap[i] = 8'hFF;
         e_an_b = 4'hF; e_sseg_b = 8'hFF;
         e_an_z = 4'hF; e_sseg_z = 8'hFF;
         e_gnt = 1'b0;
      end else begin
         tick = n % D;
         sel  = (n / D) % 4;
         dark = !valid || (tick < BL);
         e_an_b   = dark ? 4'hF : ~(4'b0001 << sel);
         e_sseg_b = dark ? 8'hFF : snap[sel];
         e_an_z   = !valid ? 4'hF : ~(4'b0001 << sel);
         e_sseg_z = !valid ? 8'hFF : snap[sel];
         if (n % FRAME == FRAME - 1) begin
            if (!own) begin
               if (b_req) begin own = 1; hold = 0; end
            end else if (!b_req && hold >= H - 1) begin
               own = 0;
            end else if (hold < H - 1) begin
               hold++;
            end
            for (int i = 0; i < 4; i++) snap[i] = own ? b_dig[i] : a_dig[i];
            valid = 1;
         end
         e_gnt = own;
         n++;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check("an", {28'd0, an_b}, {28'd0, e_an_b});
      check("sseg", {24'd0, sseg_b}, {24'd0, e_sseg_b});
      check("b_gnt", {31'd0, gnt_b}, {31'd0, e_gnt});
      check("an_noblank", {28'd0, an_z}, {28'd0, e_an_z});
      check("sseg_noblank", {24'd0, sseg_z}, {24'd0, e_sseg_z});
      check("b_gnt_noblank", {31'd0, gnt_z}, {31'd0, e_gnt});
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) cycle();
   endtask

   // Advance until the next edge is at frame position pos (bounded).
   task automatic align(input int pos);
      int guard;
      guard = 0;
      while ((n % FRAME) != pos && guard < 2 * FRAME) begin
         cycle();
         guard++;
      end
      check("align_bound", {31'd0, guard >= 2 * FRAME}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         a_dig[i] = 8'hC0;
         b_dig[i] = 8'hF9;
      end
      n = 0; own = 0; hold = 0; valid = 0;
      for (int i = 0; i < 4; i++) snap[i] = 8'hFF;

      // reset, then dark first frame and plain A scan
      reset = 1'b1;
      run(2);
      reset = 1'b0;
      run(36);
      // a_dig_2 changes mid-frame; visible only from the next frame
      a_dig[2] = 8'hA4;
      run(40);
      // B requests mid-frame, granted at the next frame boundary
      b_req = 1'b1;
      run(30);
      // drop request after one frame of ownership; hold keeps B for two
      b_req = 1'b0;
      run(90);

      // single-clock pulse away from frame_end is ignored
      align(10);
      b_req = 1'b1;
      cycle();
      b_req = 1'b0;
      run(40);

      // request held long enough, then low exactly on the frame_end cycle
      b_req = 1'b1;
      run(100);
      align(FRAME - 2);
      cycle();
      b_req = 1'b0;
      run(40);

      // reset during the sel=2 visible window
      b_req = 1'b1;
      run(40);
      align(2 * D + 4);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      run(40);
      b_req = 1'b0;

      // randomised traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(15) == 0) b_req = ~b_req;
         if ($urandom_range(7) == 0) a_dig[$urandom_range(3)] = 8'($urandom);
         if ($urandom_range(7) == 0) b_dig[$urandom_range(3)] = 8'($urandom);
         reset = ($urandom_range(499) == 0);
         cycle();
      end
      reset = 1'b0;
      run(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
